// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: gates IF/ID, ID/EX and PC writes,
// resolves load-use, taken-branch, imem-wait and multi-cycle EX hazards.
module pipeline_hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_multicycle,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        imem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        ex_hold,
  output logic        busy,
  output logic [15:0] stall_cycles
);

  // state | meaning
  // RUN   | normal issue; hazards resolved by priority each cycle
  // BUSY  | multi-cycle op occupying EX; front end frozen until cnt reaches 1
  typedef enum logic {RUN, BUSY} state_t;

  localparam logic [7:0] BUSY_LOAD = 8'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;
  logic        lu;

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
               (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    if (!res) begin
      pc_write    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      cnt_d       = 8'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_multicycle) begin
            pc_write   = imem_ready;
            ifid_flush = !imem_ready;
            if (MUL_LAT >= 2) begin
              state_d = BUSY;
              cnt_d   = BUSY_LOAD;
            end
          end else if (!imem_ready) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        BUSY: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ex_hold    = 1'b1;
          cnt_d      = cnt_q - 8'd1;
          // <= 1 rather than == 1 so a corrupted zero count cannot lock the pipe
          if (cnt_q <= 8'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign busy         = (state_q == BUSY);
  assign stall_cycles = stall_q;

endmodule
